// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller.
// Holds the coin code constants, the coin-to-unit conversion, the controller
// state type and the greedy change-coin selection used by the dispenser.
package vend_pkg;

    localparam logic [2:0] COIN_5  = 3'b001;
    localparam logic [2:0] COIN_10 = 3'b010;
    localparam logic [2:0] COIN_20 = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StCredit,
        StVend,
        StChange
    } vend_state_e;

    // Value of a coin code in 5-rupee units; 0 marks an invalid code.
    function automatic logic [2:0] coin_units(input logic [2:0] code);
        logic [2:0] units;
        case (code)
            COIN_5:  units = 3'd1;
            COIN_10: units = 3'd2;
            COIN_20: units = 3'd4;
            default: units = 3'd0;
        endcase
        return units;
    endfunction

    // Largest coin that does not exceed the remaining credit.
    function automatic logic [2:0] change_select(input int unsigned credit);
        logic [2:0] code;
        if (credit >= 4) begin
            code = COIN_20;
        end else if (credit >= 2) begin
            code = COIN_10;
        end else begin
            code = COIN_5;
        end
        return code;
    endfunction

endpackage

// File: rtl/vend_change_disp.sv
// Greedy change dispenser with a valid/ready handshake.
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   start_i, load_i   load the amount to pay out (in units) and begin
//   change_ready_i    dispenser driver accepts the offered coin
//   change_valid_o    a coin is offered
//   change_coin_o     offered coin code, stable until accepted; 0 when idle
//   rem_o             amount still to be paid out
//   done_o            the last coin is being accepted this cycle
module vend_change_disp
    import vend_pkg::*;
#(
    parameter int unsigned UNIT_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [UNIT_W-1:0] load_i,
    input  logic              change_ready_i,
    output logic              change_valid_o,
    output logic [2:0]        change_coin_o,
    output logic [UNIT_W-1:0] rem_o,
    output logic              done_o
);

    logic              active_q, active_d;
    logic [UNIT_W-1:0] rem_q, rem_d;
    logic [2:0]        coin_code;
    logic [UNIT_W-1:0] coin_val;
    logic              take;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        coin_code = change_select(32'(rem_q));
        coin_val  = UNIT_W'(coin_units(coin_code));
        take      = active_q & change_ready_i;
        // Greedy choice never exceeds rem_q, so equality marks the final coin.
        done_o    = take && (rem_q == coin_val);
        active_d  = active_q;
        rem_d     = rem_q;
        if (start_i) begin
            active_d = (load_i != '0);
            rem_d    = load_i;
        end else if (take) begin
            rem_d = rem_q - coin_val;
            if (done_o) begin
                active_d = 1'b0;
            end
        end
    end

    assign change_valid_o = active_q;
    assign change_coin_o  = active_q ? coin_code : 3'b000;
    assign rem_o          = rem_q;

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-item coin vending controller.
// Accepts 5/10/20 Rs coins into a credit accumulator (units of 5 Rs), vends a
// selected item at its per-item price and pays change or a cancel refund one
// coin per handshake through vend_change_disp.
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   coin_valid, coin         coin strobe and code
//   sel_valid, sel_item      item selection strobe and index
//   cancel                   refund request strobe
//   change_ready             change dispenser accepts a coin
//   coin_reject, sel_nack    one-cycle refusal pulses
//   vend, vend_item          one-cycle dispense pulse and item index
//   change_valid, change_coin  offered change coin
//   credit                   current credit in units
//   busy                     vending or paying change
//   sold_out                 per-item empty flags
// Optional feature: define VEND_INVENTORY_EN for per-item stock counters.
module vend_fsm_multi
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 4,
    parameter int unsigned UNIT_W = 6,
    parameter int unsigned MAX_CREDIT = 20,
    parameter logic [NUM_ITEMS*UNIT_W-1:0] ITEM_PRICES = {NUM_ITEMS{UNIT_W'(4)}},
    parameter int unsigned STOCK_INIT = 8,
    localparam int unsigned SEL_W = $clog2(NUM_ITEMS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [2:0]           coin,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel_item,
    input  logic                 cancel,
    input  logic                 change_ready,
    output logic                 coin_reject,
    output logic                 sel_nack,
    output logic                 vend,
    output logic [SEL_W-1:0]     vend_item,
    output logic                 change_valid,
    output logic [2:0]           change_coin,
    output logic [UNIT_W-1:0]    credit,
    output logic                 busy,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam int unsigned SUM_W = UNIT_W + 1;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_CREDIT);

    if (MAX_CREDIT >= (2 ** UNIT_W)) begin : g_chk_credit
        $error("MAX_CREDIT does not fit in UNIT_W bits");
    end
    if (NUM_ITEMS < 2 || NUM_ITEMS > 16) begin : g_chk_items
        $error("NUM_ITEMS must be in 2..16");
    end
    if (UNIT_W < 3 || STOCK_INIT < 1) begin : g_chk_widths
        $error("UNIT_W must hold a 20 Rs coin and STOCK_INIT must be nonzero");
    end

    vend_state_e       state_q, state_d;
    logic [UNIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]  item_q, item_d;
    logic              reject_q, reject_d;
    logic              nack_q, nack_d;

    logic [UNIT_W-1:0] price;
    logic              sel_sold;
    logic              sel_ok;
    logic [SUM_W-1:0]  coin_sum;
    logic              coin_ok;
    logic              disp_start;
    logic              disp_done;
    logic [UNIT_W-1:0] disp_rem;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            credit_q <= '0;
            item_q   <= '0;
            reject_q <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            reject_q <= reject_d;
            nack_q   <= nack_d;
        end
    end

    // Next-state logic.
    always_comb begin
        price    = '0;
        sel_sold = 1'b0;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (32'(sel_item) == i) begin
                price    = ITEM_PRICES[i*UNIT_W +: UNIT_W];
                sel_sold = sold_out[i];
            end
        end
        sel_ok   = (32'(sel_item) < NUM_ITEMS) && (credit_q >= price) && !sel_sold;
        coin_sum = {1'b0, credit_q} + SUM_W'(coin_units(coin));
        coin_ok  = (coin_units(coin) != 3'd0) && (coin_sum <= MAX_SUM);

        state_d    = state_q;
        credit_d   = credit_q;
        item_d     = item_q;
        reject_d   = 1'b0;
        nack_d     = 1'b0;
        disp_start = 1'b0;

        unique case (state_q)
            StIdle, StCredit: begin
                if (cancel) begin
                    // Cancel owns the cycle even when there is nothing to refund.
                    reject_d = coin_valid;
                    nack_d   = sel_valid;
                    if (credit_q != '0) begin
                        state_d    = StChange;
                        disp_start = 1'b1;
                        credit_d   = '0;
                    end
                end else if (sel_valid) begin
                    reject_d = coin_valid;
                    if (sel_ok) begin
                        state_d  = StVend;
                        credit_d = credit_q - price;
                        item_d   = sel_item;
                    end else begin
                        nack_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[UNIT_W-1:0];
                        state_d  = StCredit;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StVend: begin
                reject_d = coin_valid;
                nack_d   = sel_valid;
                if (credit_q != '0) begin
                    // The dispenser takes over the remainder; credit is read from it.
                    state_d    = StChange;
                    disp_start = 1'b1;
                    credit_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StChange: begin
                reject_d = coin_valid;
                nack_d   = sel_valid;
                if (disp_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        vend        = (state_q == StVend);
        vend_item   = vend ? item_q : '0;
        busy        = (state_q == StVend) || (state_q == StChange);
        coin_reject = reject_q;
        sel_nack    = nack_q;
        credit      = (state_q == StChange) ? disp_rem : credit_q;
    end

    vend_change_disp #(
        .UNIT_W (UNIT_W)
    ) u_change_disp (
        .clk_i          (clock),
        .rst_i          (reset),
        .start_i        (disp_start),
        .load_i         (credit_q),
        .change_ready_i (change_ready),
        .change_valid_o (change_valid),
        .change_coin_o  (change_coin),
        .rem_o          (disp_rem),
        .done_o         (disp_done)
    );

`ifdef VEND_INVENTORY_EN
    localparam int unsigned STOCK_W = $clog2(STOCK_INIT + 1);

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            stock_q <= stock_d;
        end
    end

    always_comb begin
        stock_d = stock_q;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (state_q == StVend && 32'(item_q) == i && stock_q[i] != '0) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end
`else
    assign sold_out = '0;
`endif

endmodule

// File: tb/tb_vend_fsm_multi.sv
module tb_vend_fsm_multi;

    localparam logic [2:0] C5  = 3'b001;
    localparam logic [2:0] C10 = 3'b010;
    localparam logic [2:0] C20 = 3'b101;
    localparam int MAXC = 20;
`ifdef VEND_INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [2:0] coin = 3'b000;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'd0;
    logic       cancel = 1'b0;
    logic       change_ready = 1'b1;
    logic       coin_reject, sel_nack, vend, change_valid, busy;
    logic [1:0] vend_item;
    logic [2:0] change_coin;
    logic [5:0] credit;
    logic [3:0] sold_out;

    int n_checks = 0;
    int n_fail = 0;

    vend_fsm_multi #(
        .NUM_ITEMS   (4),
        .UNIT_W      (6),
        .MAX_CREDIT  (20),
        .ITEM_PRICES ({6'd4, 6'd4, 6'd3, 6'd4}),
        .STOCK_INIT  (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .change_ready (change_ready),
        .coin_reject  (coin_reject),
        .sel_nack     (sel_nack),
        .vend         (vend),
        .vend_item    (vend_item),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .credit       (credit),
        .busy         (busy),
        .sold_out     (sold_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  price [4] = '{4, 3, 4, 4};
    int  m_credit;
    int  m_phase;   // 0 accepting, 1 dispensing item, 2 paying out
    int  m_item;
    int  m_stock [4];
    bit  m_rej, m_nack, m_live = 1'b0;
    int  s, u;

    function automatic int units_of(input logic [2:0] c);
        if (c == C5) return 1;
        if (c == C10) return 2;
        if (c == C20) return 4;
        return 0;
    endfunction

    function automatic int greedy(input int c);
        return (c >= 4) ? 4 : (c >= 2) ? 2 : 1;
    endfunction

    function automatic logic [2:0] code_of(input int units);
        return (units == 4) ? C20 : (units == 2) ? C10 : C5;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1'b1;
            m_credit = 0;
            m_phase = 0;
            m_item = 0;
            m_rej = 1'b0;
            m_nack = 1'b0;
            for (int i = 0; i < 4; i++) m_stock[i] = 1;
        end else if (m_live) begin
            m_rej = coin_valid;
            m_nack = sel_valid;
            if (m_phase == 0) begin
                if (cancel) begin
                    if (m_credit > 0) m_phase = 2;
                end else if (sel_valid) begin
                    s = int'(sel_item);
                    if (m_credit >= price[s] && (!INV || m_stock[s] > 0)) begin
                        m_credit -= price[s];
                        m_item = s;
                        m_phase = 1;
                        m_nack = 1'b0;
                    end
                end else begin
                    m_nack = 1'b0;
                    m_rej = 1'b0;
                    if (coin_valid) begin
                        u = units_of(coin);
                        if (u == 0 || m_credit + u > MAXC) m_rej = 1'b1;
                        else m_credit += u;
                    end
                end
            end else if (m_phase == 1) begin
                if (INV) m_stock[m_item]--;
                m_phase = (m_credit > 0) ? 2 : 0;
            end else begin
                if (change_ready) begin
                    m_credit -= greedy(m_credit);
                    if (m_credit == 0) m_phase = 0;
                end
            end
        end
    end

    // Compare every cycle once the model has seen reset.
    always @(negedge clock) begin
        if (m_live) begin
            logic [3:0] exp_so;
            for (int i = 0; i < 4; i++) exp_so[i] = INV && (m_stock[i] == 0);
            check("credit", 32'(credit), 32'(m_credit));
            check("coin_reject", 32'(coin_reject), 32'(m_rej));
            check("sel_nack", 32'(sel_nack), 32'(m_nack));
            check("vend", 32'(vend), 32'(m_phase == 1));
            check("vend_item", 32'(vend_item), (m_phase == 1) ? 32'(m_item) : 32'd0);
            check("change_valid", 32'(change_valid), 32'(m_phase == 2));
            check("change_coin", 32'(change_coin),
                  (m_phase == 2) ? 32'(code_of(greedy(m_credit))) : 32'd0);
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("sold_out", 32'(sold_out), 32'(exp_so));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put_coin(input logic [2:0] c);
        coin = c;
        coin_valid = 1'b1;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic pick(input logic [1:0] item);
        sel_item = item;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30 && busy; i++) tick();
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_change_valid", 32'(change_valid), 32'd0);
        reset = 1'b0;
        tick();

        // Two 10 Rs coins then item 0 (price 4): exact payment, no change.
        put_coin(C10);
        check("t1_credit2", 32'(credit), 32'd2);
        put_coin(C10);
        check("t1_credit4", 32'(credit), 32'd4);
        pick(2'd0);
        check("t1_vend", 32'(vend), 32'd1);
        check("t1_vend_item", 32'(vend_item), 32'd0);
        check("t1_credit0", 32'(credit), 32'd0);
        tick();
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_no_change", 32'(change_valid), 32'd0);

        // 20 Rs, item 1 (price 3): one 5 Rs coin back.
        put_coin(C20);
        pick(2'd1);
        check("t2_vend_item", 32'(vend_item), 32'd1);
        check("t2_credit1", 32'(credit), 32'd1);
        tick();
        check("t2_change_valid", 32'(change_valid), 32'd1);
        check("t2_change_coin", 32'(change_coin), 32'(C5));
        tick();
        check("t2_done_valid", 32'(change_valid), 32'd0);
        check("t2_done_credit", 32'(credit), 32'd0);

        // Credit 7, cancel with the dispenser stalled for three cycles.
        put_coin(C20);
        put_coin(C10);
        put_coin(C5);
        check("t3_credit7", 32'(credit), 32'd7);
        change_ready = 1'b0;
        do_cancel();
        tick();
        tick();
        check("t3_hold_coin", 32'(change_coin), 32'(C20));
        check("t3_hold_credit", 32'(credit), 32'd7);
        change_ready = 1'b1;
        tick();
        check("t3_after20", 32'(credit), 32'd3);
        check("t3_coin10", 32'(change_coin), 32'(C10));
        tick();
        check("t3_coin5", 32'(change_coin), 32'(C5));
        tick();
        check("t3_done", 32'(change_valid), 32'd0);

        // Overflow and invalid code rejection at credit 18.
        put_coin(C20);
        put_coin(C20);
        put_coin(C20);
        put_coin(C20);
        put_coin(C10);
        check("t4_credit18", 32'(credit), 32'd18);
        put_coin(C20);
        check("t4_overflow_reject", 32'(coin_reject), 32'd1);
        check("t4_credit_kept", 32'(credit), 32'd18);
        put_coin(3'b111);
        check("t4_invalid_reject", 32'(coin_reject), 32'd1);
        do_cancel();
        wait_idle("t4_refund_done");

        // Selection wins over a same-cycle coin.
        put_coin(C20);
        sel_item = 2'd3;
        sel_valid = 1'b1;
        coin = C10;
        coin_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        coin_valid = 1'b0;
        check("t5_vend", 32'(vend), 32'd1);
        check("t5_vend_item", 32'(vend_item), 32'd3);
        check("t5_coin_reject", 32'(coin_reject), 32'd1);
        tick();

        // Reset in the middle of a refund.
        put_coin(C20);
        put_coin(C10);
        put_coin(C5);
        change_ready = 1'b0;
        do_cancel();
        tick();
        reset = 1'b1;
        tick();
        check("t6_change_valid", 32'(change_valid), 32'd0);
        check("t6_change_coin", 32'(change_coin), 32'd0);
        check("t6_credit", 32'(credit), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        change_ready = 1'b1;
        tick();

        // Item 2 twice; with stock of one the second selection is refused.
        put_coin(C20);
        pick(2'd2);
        tick();
`ifdef VEND_INVENTORY_EN
        check("t7_sold_out2", 32'(sold_out[2]), 32'd1);
`endif
        put_coin(C20);
        pick(2'd2);
`ifdef VEND_INVENTORY_EN
        check("t7_nack", 32'(sel_nack), 32'd1);
        check("t7_credit_kept", 32'(credit), 32'd4);
        do_cancel();
`endif
        wait_idle("t7_idle");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
